// File: rtl/cordic_sched_pkg.sv
// cordic_sched_pkg: shared types and defaults for the CORDIC scheduler
package cordic_sched_pkg;
  localparam int CORDIC_LAT_DEFAULT = 8;
  // Tag IDs are sized for the largest supported requester count; the top truncates to ID_W.
  localparam int TAG_ID_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;
  typedef struct packed {
    logic valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter with a registered rotating start pointer
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic gnt_valid,
  output logic [ID_W-1:0] gnt_id
);
  logic [ID_W-1:0] ptr;
  logic [NUM_REQ-1:0] rot;
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    gnt_valid = 1'b0;
    gnt_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (en && rot[i]) begin
        gnt_valid = 1'b1;
        gnt_id = ID_W'(int'(ptr) + i >= NUM_REQ ? int'(ptr) + i - NUM_REQ : int'(ptr) + i);
      end
    gnt = gnt_valid ? NUM_REQ'(1) << gnt_id : '0;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) ptr <= '0;
    else if (gnt_valid) ptr <= gnt_id == ID_W'(NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
endmodule

// File: rtl/cordic_scheduler.sv
// cordic_scheduler: round-robin sharing of one CORDIC pipeline; CORDIC_SCHED_STATS_EN adds per-requester grant counters
module cordic_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CORDIC_LAT = CORDIC_LAT_DEFAULT,
  parameter int ID_W = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic i_enable,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [4*NUM_REQ-1:0] i_I_req,
  input  logic [4*NUM_REQ-1:0] i_Q_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [3:0] o_cordic_I,
  output logic [3:0] o_cordic_Q,
  output logic o_cordic_reset,
  input  logic [15:0] i_cordic_angle,
  output logic [NUM_REQ-1:0] o_res_valid,
  output logic [15:0] o_res_angle,
  output logic [ID_W-1:0] o_res_id,
  output logic o_idle
`ifdef CORDIC_SCHED_STATS_EN
  ,
  input  logic i_stats_clr,
  output logic [16*NUM_REQ-1:0] o_grant_cnt
`endif
);
  sched_state_t state, state_nx;
  logic run, busy, gnt_valid;
  logic [ID_W-1:0] gnt_id;
  tag_t tags [CORDIC_LAT+1];
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clock(clock),
    .reset(reset),
    .en(run),
    .req(i_req),
    .gnt(o_gnt),
    .gnt_valid(gnt_valid),
    .gnt_id(gnt_id)
  );
  always_comb begin
    busy = |o_res_valid;
    for (int i = 0; i <= CORDIC_LAT; i++) busy = busy | tags[i].valid;
    run = state == RUN && i_enable;
    o_idle = state == IDLE;
    state_nx = i_enable ? RUN : (state == IDLE || (state == DRAIN && !busy)) ? IDLE : DRAIN;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // The last tag stage lines up with i_cordic_angle, so the result register samples both together.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      o_cordic_I <= '0;
      o_cordic_Q <= '0;
      o_cordic_reset <= 1'b1;
      o_res_valid <= '0;
      o_res_angle <= '0;
      o_res_id <= '0;
      for (int i = 0; i <= CORDIC_LAT; i++) tags[i] <= '0;
    end else begin
      o_cordic_I <= gnt_valid ? 4'(i_I_req >> {gnt_id, 2'b00}) : '0;
      o_cordic_Q <= gnt_valid ? 4'(i_Q_req >> {gnt_id, 2'b00}) : '0;
      o_cordic_reset <= state_nx == IDLE;
      tags[0] <= '{valid: gnt_valid, id: TAG_ID_W'(gnt_id)};
      for (int i = 1; i <= CORDIC_LAT; i++) tags[i] <= tags[i-1];
      o_res_valid <= tags[CORDIC_LAT].valid ? NUM_REQ'(1) << tags[CORDIC_LAT].id : '0;
      if (tags[CORDIC_LAT].valid) begin
        o_res_angle <= i_cordic_angle;
        o_res_id <= ID_W'(tags[CORDIC_LAT].id);
      end
    end
`ifdef CORDIC_SCHED_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt;
  assign o_grant_cnt = cnt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        if (i_stats_clr) cnt[i] <= '0;
        else if (o_gnt[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
`endif
endmodule

// File: tb/tb_cordic_scheduler.sv
// tb_cordic_scheduler: randomized scoreboard bench for cordic_scheduler with a delay-line CORDIC stub
module tb_cordic_scheduler;
  localparam int N = 3;
  localparam int LAT = 8;
  localparam int IW = 3;
  logic clock = 0, reset = 1, i_enable = 0;
  logic [N-1:0] i_req = 0, o_gnt, o_res_valid;
  logic [4*N-1:0] i_I_req = 0, i_Q_req = 0;
  logic [3:0] o_cordic_I, o_cordic_Q;
  logic o_cordic_reset, o_idle;
  logic [15:0] i_cordic_angle, o_res_angle;
  logic [IW-1:0] o_res_id;
`ifdef CORDIC_SCHED_STATS_EN
  logic i_stats_clr = 0;
  logic [16*N-1:0] o_grant_cnt;
`endif
  always #5 clock = ~clock;
  cordic_scheduler #(.NUM_REQ(N), .CORDIC_LAT(LAT), .ID_W(IW)) dut (
    .clock(clock),
    .reset(reset),
    .i_enable(i_enable),
    .i_req(i_req),
    .i_I_req(i_I_req),
    .i_Q_req(i_Q_req),
    .o_gnt(o_gnt),
    .o_cordic_I(o_cordic_I),
    .o_cordic_Q(o_cordic_Q),
    .o_cordic_reset(o_cordic_reset),
    .i_cordic_angle(i_cordic_angle),
    .o_res_valid(o_res_valid),
    .o_res_angle(o_res_angle),
    .o_res_id(o_res_id),
    .o_idle(o_idle)
`ifdef CORDIC_SCHED_STATS_EN
    ,
    .i_stats_clr(i_stats_clr),
    .o_grant_cnt(o_grant_cnt)
`endif
  );
  // CORDIC stand-in: returns {8'h00, I, Q} LAT edges after sampling its input.
  logic [7:0] dl [LAT];
  always @(posedge clock)
    if (o_cordic_reset) for (int i = 0; i < LAT; i++) dl[i] <= 8'h00;
    else begin
      dl[0] <= {o_cordic_I, o_cordic_Q};
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
  assign i_cordic_angle = {8'h00, dl[LAT-1]};
  typedef struct {
    int id;
    logic [15:0] ang;
    int due;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int errors = 0, checks = 0, cyc = 0, mptr = 0;
  logic prev_en = 0;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Reference: a grant is possible only when enable was high last cycle and is high now;
  // the winner is the first requester at or after the rotating pointer.
  task automatic step(input logic en, input logic [N-1:0] r, input logic [4*N-1:0] iv, input logic [4*N-1:0] qv);
    int k;
    @(negedge clock);
    i_enable = en;
    i_req = r;
    i_I_req = iv;
    i_Q_req = qv;
    #2;
    k = -1;
    if (prev_en && en)
      for (int i = 0; i < N; i++) begin
        int c = (mptr + i) % N;
        if (k < 0 && ((r >> c) & 1) != 0) k = c;
      end
    check("gnt", 32'(o_gnt), k < 0 ? 32'd0 : 32'd1 << k);
    if (k >= 0) begin
      q.push_back('{k, {8'h00, 4'(iv >> (4 * k)), 4'(qv >> (4 * k))}, cyc + LAT + 2});
      mptr = (k + 1) % N;
    end
    prev_en = en;
  endtask
  always @(negedge clock)
    if (reset) begin
      if (o_res_valid != 0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected result: valid=%b id=%0d angle=%h", o_res_valid, o_res_id, o_res_angle);
        end else begin
          mon_e = q.pop_front();
          check("res_valid", 32'(o_res_valid), 32'd1 << mon_e.id);
          check("res_id", 32'(o_res_id), mon_e.id);
          check("res_angle", 32'(o_res_angle), 32'(mon_e.ang));
          check("res_latency", cyc, mon_e.due);
        end
      end else if (q.size() != 0 && cyc > q[0].due) begin
        checks++;
        errors++;
        $display("FAIL missing result: id=%0d due=%0d now=%0d", q[0].id, q[0].due, cyc);
        void'(q.pop_front());
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bit idle_seen;
    #1 reset = 0;
    repeat (2) @(negedge clock);
    check("rst_idle", 32'(o_idle), 1);
    check("rst_cordic_reset", 32'(o_cordic_reset), 1);
    check("rst_res_valid", 32'(o_res_valid), 0);
    check("rst_res_angle", 32'(o_res_angle), 0);
    check("rst_gnt", 32'(o_gnt), 0);
    check("rst_cordic_iq", 32'({o_cordic_I, o_cordic_Q}), 0);
    reset = 1;
    step(1, 3'b000, 0, 0);
    step(1, 3'b001, 12'h003, 12'h00A);
    check("cordic_reset_run", 32'(o_cordic_reset), 0);
    check("idle_run", 32'(o_idle), 0);
    repeat (12) step(1, 3'b000, 0, 0);
    repeat (12) step(1, 3'b111, 12'($urandom), 12'($urandom));
    step(1, 3'b010, 12'($urandom), 12'($urandom));
    step(1, 3'b011, 12'($urandom), 12'($urandom));
    step(1, 3'b011, 12'($urandom), 12'($urandom));
    repeat (12) step(1, 3'b000, 0, 0);
    repeat (5) step(1, 3'b111, 12'($urandom), 12'($urandom));
    step(0, 3'b111, 12'($urandom), 12'($urandom));
    idle_seen = 0;
    for (int i = 0; i < 40 && !idle_seen; i++) begin
      @(negedge clock);
      #3;
      check("drain_gnt", 32'(o_gnt), 0);
      if (o_idle) begin
        idle_seen = 1;
        check("idle_after_results", q.size(), 0);
        check("cordic_reset_idle", 32'(o_cordic_reset), 1);
      end
    end
    check("drain_reached_idle", 32'(idle_seen), 1);
    step(1, 3'b000, 0, 0);
    repeat (4) step(1, 3'b111, 12'($urandom), 12'($urandom));
    @(posedge clock);
    #2 reset = 0;
    #1;
    check("arst_res_valid", 32'(o_res_valid), 0);
    check("arst_res_angle", 32'(o_res_angle), 0);
    check("arst_res_id", 32'(o_res_id), 0);
    check("arst_cordic_iq", 32'({o_cordic_I, o_cordic_Q}), 0);
    check("arst_cordic_reset", 32'(o_cordic_reset), 1);
    check("arst_idle", 32'(o_idle), 1);
    check("arst_gnt", 32'(o_gnt), 0);
    q.delete();
    mptr = 0;
    prev_en = 0;
    i_enable = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    repeat (15) step(0, 3'b000, 0, 0);
`ifdef CORDIC_SCHED_STATS_EN
    step(1, 3'b000, 0, 0);
    repeat (300) step(1, 3'b010, 12'($urandom), 12'($urandom));
    @(negedge clock);
    check("grant_cnt_300", 32'(o_grant_cnt[31:16]), 300);
    i_stats_clr = 1;
    @(negedge clock);
    i_stats_clr = 0;
    check("grant_cnt_clr", 32'(o_grant_cnt[31:16]), 0);
`endif
    repeat (300) step($urandom_range(0, 9) != 0, 3'($urandom), 12'($urandom), 12'($urandom));
    repeat (20) step(0, 3'b000, 0, 0);
    check("queue_empty_end", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
